// File: rtl/alu_pkg.sv
// alu_pkg: shared nibble width, sequencer state encoding and index width helper
package alu_pkg;
  localparam int NIBBLE_W = 4;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// nibble_serial_add_ctrl_if: operand request and result handshake bundle
interface nibble_serial_add_ctrl_if #(parameter int NIBBLES = 4);
  import alu_pkg::*;
  localparam int W = NIBBLE_W * NIBBLES;
  logic in_valid, in_ready, sub, out_valid, out_ready, carry_out, overflow;
  logic [W-1:0] op_a, op_b, result;
  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow
  );
  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: wide add/sub sequenced LSB-first through an external 4-bit adder
module nibble_serial_add_ctrl
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  nibble_serial_add_ctrl_if.slave bus,
  output logic [NIBBLE_W-1:0] add_a,
  output logic [NIBBLE_W-1:0] add_b,
  output logic                add_ci,
  input  logic [NIBBLE_W-1:0] add_s,
  input  logic                add_co
);
  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = idx_w(NIBBLES);
  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg, b_reg, res;
  logic          carry_reg, co, ov, ovld, last;
  assign last          = idx == IW'(NIBBLES - 1);
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = ovld;
  assign bus.result    = res;
  assign bus.carry_out = co;
  assign bus.overflow  = ov;
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (state == RUN) begin
      add_ci = carry_reg;
      for (int i = 0; i < NIBBLES; i++)
        if (idx == IW'(i)) begin
          add_a = a_reg[i*NIBBLE_W +: NIBBLE_W];
          add_b = b_reg[i*NIBBLE_W +: NIBBLE_W];
        end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      res       <= '0;
      co        <= 1'b0;
      ov        <= 1'b0;
      ovld      <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      a_reg     <= bus.op_a;
      b_reg     <= bus.sub ? ~bus.op_b : bus.op_b;
      carry_reg <= bus.sub;
      idx       <= '0;
      state     <= RUN;
    end else if (state == RUN) begin
      for (int i = 0; i < NIBBLES; i++)
        if (idx == IW'(i)) res[i*NIBBLE_W +: NIBBLE_W] <= add_s;
      carry_reg <= add_co;
      if (last) begin
        state <= DONE;
        co    <= add_co;
        ov    <= (a_reg[W-1] == b_reg[W-1]) && (add_s[NIBBLE_W-1] != a_reg[W-1]);
        ovld  <= 1'b1;
      end else idx <= idx + IW'(1);
    end else if (state == DONE && bus.out_ready) begin
      ovld  <= 1'b0;
      state <= IDLE;
    end
  end
endmodule
